// File: rtl/wb_commit_stage.sv
// Multi-lane in-order write-back/commit stage: per-lane GR writes, single flush resolution, retire counter.
// Optional WB_TRACE_SERIAL_EN serialises the debug trace to one retiring lane per cycle (TW=1).
module wb_commit_stage #(
    parameter int unsigned LANES = 2,
    localparam int unsigned RN_W = $clog2(LANES + 1),
`ifdef WB_TRACE_SERIAL_EN
    localparam int unsigned TW = 1
`else
    localparam int unsigned TW = LANES
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ms_to_ws_valid,
    output logic                  ws_allowin,
    input  logic [LANES-1:0]      ms_lane_valid,
    input  logic [32*LANES-1:0]   ms_pc,
    input  logic [32*LANES-1:0]   ms_result,
    input  logic [32*LANES-1:0]   ms_error_va,
    input  logic [5*LANES-1:0]    ms_dest,
    input  logic [LANES-1:0]      ms_gr_we,
    input  logic [LANES-1:0]      ms_ertn,
    input  logic [LANES-1:0]      ms_idle,
    input  logic [LANES-1:0]      ms_refetch,
    input  logic [16*LANES-1:0]   ms_excp_num,
    input  logic                  debug_break_point,
    output logic [LANES-1:0]      rf_we,
    output logic [5*LANES-1:0]    rf_waddr,
    output logic [32*LANES-1:0]   rf_wdata,
    output logic                  excp_flush,
    output logic                  ertn_flush,
    output logic                  idle_flush,
    output logic                  refetch_flush,
    output logic [31:0]           flush_pc,
    output logic [5:0]            csr_ecode,
    output logic [8:0]            csr_esubcode,
    output logic                  va_error,
    output logic [31:0]           bad_va,
    output logic                  excp_tlbrefill,
    output logic [RN_W-1:0]       retire_num,
    output logic [63:0]           retire_cnt,
    output logic [32*TW-1:0]      debug_wb_pc,
    output logic [4*TW-1:0]       debug_wb_rf_wen,
    output logic [5*TW-1:0]       debug_wb_rf_wnum,
    output logic [32*TW-1:0]      debug_wb_rf_wdata
);

    logic                ws_valid;
    logic [LANES-1:0]    lane_valid_q, gr_we_q, ertn_q, idle_q, refetch_q;
    logic [32*LANES-1:0] pc_q, result_q, error_va_q;
    logic [5*LANES-1:0]  dest_q;
    logic [16*LANES-1:0] excp_q;

    logic                ws_ready_go;
    logic                ws_done;
    logic                blocked;
    logic [LANES-1:0]    cause, live, retire, we_lane;

    logic                k_any;
    logic [15:0]         sel_excp;
    logic                sel_ertn, sel_idle;
    logic [31:0]         sel_pc, sel_va;
    logic                flush_go;

    logic                ex_found, ex_use_pc, ex_use_va, ex_tlbr;
    logic [5:0]          ex_code;

    assign ws_ready_go = ~debug_break_point;
    assign ws_allowin  = ~ws_valid | ws_done;

    // Bundle valid: flush wins over an incoming bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (flush_go) begin
                ws_valid <= 1'b0;
            end else if (ws_allowin) begin
                ws_valid <= ms_to_ws_valid;
            end
            retire_cnt <= retire_cnt + 64'(retire_num);
        end
    end

    // Bundle payload register
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_valid_q <= '0;
            gr_we_q      <= '0;
            ertn_q       <= '0;
            idle_q       <= '0;
            refetch_q    <= '0;
            pc_q         <= '0;
            result_q     <= '0;
            error_va_q   <= '0;
            dest_q       <= '0;
            excp_q       <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            lane_valid_q <= ms_lane_valid;
            gr_we_q      <= ms_gr_we;
            ertn_q       <= ms_ertn;
            idle_q       <= ms_idle;
            refetch_q    <= ms_refetch;
            pc_q         <= ms_pc;
            result_q     <= ms_result;
            error_va_q   <= ms_error_va;
            dest_q       <= ms_dest;
            excp_q       <= ms_excp_num;
        end
    end

    // Lane liveness: any older lane with a cause squashes everything younger
    always_comb begin
        blocked = 1'b0;
        cause   = '0;
        live    = '0;
        retire  = '0;
        for (int i = 0; i < LANES; i++) begin
            cause[i]  = (|excp_q[16*i +: 16]) | ertn_q[i] | idle_q[i] | refetch_q[i];
            live[i]   = ws_valid & lane_valid_q[i] & ~blocked;
            retire[i] = live[i] & ~(|excp_q[16*i +: 16]);
            blocked   = blocked | (lane_valid_q[i] & cause[i]);
        end
    end

    // Same-destination writes within a bundle: youngest lane wins
    always_comb begin
        we_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            we_lane[i] = retire[i] & gr_we_q[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (retire[j] && gr_we_q[j] && (dest_q[5*j +: 5] == dest_q[5*i +: 5])) begin
                    we_lane[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rf_we      = '0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        retire_num = '0;
        if (ws_done) begin
            rf_we = we_lane;
            for (int i = 0; i < LANES; i++) begin
                retire_num = retire_num + RN_W'(retire[i]);
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (rf_we[i]) begin
                rf_waddr[5*i +: 5]  = dest_q[5*i +: 5];
                rf_wdata[32*i +: 32] = result_q[32*i +: 32];
            end
        end
    end

    // Oldest live lane carrying a cause owns the flush
    always_comb begin
        k_any    = 1'b0;
        sel_excp = '0;
        sel_ertn = 1'b0;
        sel_idle = 1'b0;
        sel_pc   = '0;
        sel_va   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!k_any && live[i] && cause[i]) begin
                k_any    = 1'b1;
                sel_excp = excp_q[16*i +: 16];
                sel_ertn = ertn_q[i];
                sel_idle = idle_q[i];
                sel_pc   = pc_q[32*i +: 32];
                sel_va   = error_va_q[32*i +: 32];
            end
        end
    end

    assign flush_go      = ws_done & k_any;
    assign excp_flush    = flush_go & (|sel_excp);
    assign ertn_flush    = flush_go & ~(|sel_excp) & sel_ertn;
    assign idle_flush    = flush_go & ~(|sel_excp) & ~sel_ertn & sel_idle;
    assign refetch_flush = flush_go & ~(|sel_excp) & ~sel_ertn & ~sel_idle;
    assign flush_pc      = flush_go ? sel_pc : 32'h0;

    // Exception decode: lowest set vector bit wins; bit 10 is reserved
    always_comb begin
        ex_found  = 1'b0;
        ex_code   = '0;
        ex_use_pc = 1'b0;
        ex_use_va = 1'b0;
        ex_tlbr   = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (!ex_found && sel_excp[b]) begin
                ex_found = 1'b1;
                case (b)
                    1:  begin ex_code = 6'h08; ex_use_pc = 1'b1; end
                    2:  begin ex_code = 6'h3F; ex_use_pc = 1'b1; ex_tlbr = 1'b1; end
                    3:  begin ex_code = 6'h03; ex_use_pc = 1'b1; end
                    4:  begin ex_code = 6'h07; ex_use_pc = 1'b1; end
                    5:  ex_code = 6'h0B;
                    6:  ex_code = 6'h0C;
                    7:  ex_code = 6'h0D;
                    8:  ex_code = 6'h0E;
                    9:  begin ex_code = 6'h09; ex_use_va = 1'b1; end
                    11: begin ex_code = 6'h3F; ex_use_va = 1'b1; ex_tlbr = 1'b1; end
                    12: begin ex_code = 6'h04; ex_use_va = 1'b1; end
                    13: begin ex_code = 6'h07; ex_use_va = 1'b1; end
                    14: begin ex_code = 6'h02; ex_use_va = 1'b1; end
                    15: begin ex_code = 6'h01; ex_use_va = 1'b1; end
                    default: ex_code = 6'h00;
                endcase
            end
        end
    end

    always_comb begin
        csr_ecode      = '0;
        csr_esubcode   = '0;
        va_error       = 1'b0;
        bad_va         = '0;
        excp_tlbrefill = 1'b0;
        if (excp_flush) begin
            csr_ecode      = ex_code;
            va_error       = ex_use_pc | ex_use_va;
            excp_tlbrefill = ex_tlbr;
            if (ex_use_pc) begin
                bad_va = sel_pc;
            end else if (ex_use_va) begin
                bad_va = sel_va;
            end
        end
    end

`ifdef WB_TRACE_SERIAL_EN
    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [IW-1:0] idx_q, idx_d;
    logic          has_emit, more, emit_act;
    logic [IW-1:0] emit;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Emit lane: oldest retiring lane at or after the current index
    always_comb begin
        has_emit = 1'b0;
        more     = 1'b0;
        emit     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (retire[i] && (32'(i) >= 32'(idx_q))) begin
                if (!has_emit) begin
                    has_emit = 1'b1;
                    emit     = IW'(i);
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    assign ws_done  = ws_ready_go & ~(has_emit & more);
    assign emit_act = ws_valid & ws_ready_go & has_emit;

    always_comb begin
        idx_d = idx_q;
        if (flush_go || ws_done) begin
            idx_d = '0;
        end else if (emit_act) begin
            idx_d = emit + IW'(1);
        end
    end

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (emit_act && (emit == IW'(i))) begin
                debug_wb_pc       = pc_q[32*i +: 32];
                debug_wb_rf_wen   = {4{we_lane[i]}};
                debug_wb_rf_wnum  = we_lane[i] ? dest_q[5*i +: 5] : 5'h0;
                debug_wb_rf_wdata = we_lane[i] ? result_q[32*i +: 32] : 32'h0;
            end
        end
    end
`else
    assign ws_done = ws_ready_go;

    // Parallel trace mirrors the register-file write ports lane by lane
    always_comb begin
        debug_wb_pc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (ws_done && retire[i]) begin
                debug_wb_pc[32*i +: 32] = pc_q[32*i +: 32];
            end
            debug_wb_rf_wen[4*i +: 4] = {4{rf_we[i]}};
        end
    end

    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule
